pump_sequencer: RTL and testbench

PUMP_SEQUENCER -- requirements
Module: pump_sequencer

---
 rtl/pump_sequencer.sv | 219 +++++++++++++++++++++
 tb/tb_pump_sequencer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/pump_sequencer.sv
// -----------------------------------------------------------------------------
// pump_sequencer
//   Soft-start / soft-stop sequencer for two mutually exclusive pumps.
//   Pump A fills and pump B returns/drains. A request is granted in IDLE, with
//   B winning ties. The duty then ramps up to PWM_TARGET, holds in RUN, ramps
//   back down to zero, and waits DEAD_TIME idle cycles before the next grant.
//
//   Optional feature, macro PUMP_SEQ_FILL_TIMEOUT_EN:
//     Adds a fill watchdog. Pump A may stay on (RAMP_UP/RUN) without the full
//     float for at most FILL_TIMEOUT cycles. When that limit is reached the
//     block latches FAULT and stays there until the fault is cleared with both
//     requests low.
//
// Ports
//   clk_fpga      in   1  system clock
//   reset         in   1  asynchronous reset, active low
//   i_req_a       in   1  run request, pump A (fill)
//   i_req_b       in   1  run request, pump B (return/drain)
//   i_boia_cheia  in   1  full float, already synchronised
//   i_fault_clr   in   1  fault clear pulse
//   o_duty_a      out  8  duty cycle to the pump A PWM generator
//   o_duty_b      out  8  duty cycle to the pump B PWM generator
//   o_busy        out  1  high in every state except IDLE
//   o_fault       out  1  fill-timeout fault latched
// -----------------------------------------------------------------------------
module pump_sequencer #(
  parameter logic [7:0]  PWM_TARGET   = 8'd230,
  parameter logic [7:0]  RAMP_STEP    = 8'd10,
  parameter int unsigned RAMP_TICK    = 1000,
  parameter int unsigned DEAD_TIME    = 500,
  parameter int unsigned FILL_TIMEOUT = 50_000_000
) (
  input  logic       clk_fpga,
  input  logic       reset,
  input  logic       i_req_a,
  input  logic       i_req_b,
  input  logic       i_boia_cheia,
  input  logic       i_fault_clr,
  output logic [7:0] o_duty_a,
  output logic [7:0] o_duty_b,
  output logic       o_busy,
  output logic       o_fault
);

  typedef enum logic [2:0] {
    IDLE,
    RAMP_UP,
    RUN,
    RAMP_DOWN,
    DEAD
`ifdef PUMP_SEQ_FILL_TIMEOUT_EN
    , FAULT
`endif
  } state_t;

  state_t      state, state_nxt;
  logic        sel, sel_nxt;            // 0 = pump A, 1 = pump B
  logic [7:0]  duty, duty_nxt;
  logic [31:0] tick_cnt, tick_nxt;
  logic [31:0] dead_cnt, dead_nxt;

  logic        abort;
  logic        tick_hit;
  logic [8:0]  duty_sum;
  logic [7:0]  duty_up, duty_dn;

  // Ramp arithmetic is done in 9 bits so the sum saturates instead of wrapping.
  assign duty_sum = {1'b0, duty} + {1'b0, RAMP_STEP};
  assign duty_up  = (duty_sum >= {1'b0, PWM_TARGET}) ? PWM_TARGET : duty_sum[7:0];
  assign duty_dn  = (duty > RAMP_STEP) ? (duty - RAMP_STEP) : 8'd0;
  assign tick_hit = (tick_cnt == RAMP_TICK - 32'd1);

  // The active pump stops when its own request drops or the other one asks.
  assign abort = sel ? (!i_req_b || i_req_a) : (!i_req_a || i_req_b);

`ifdef PUMP_SEQ_FILL_TIMEOUT_EN
  logic [31:0] fill_cnt, fill_nxt;
  logic        fill_run;
  assign fill_run = !sel && !i_boia_cheia && (state == RAMP_UP || state == RUN);
`else
  // The watchdog inputs and its limit have no function in this build.
  logic unused_fill;
  assign unused_fill = ^{i_boia_cheia, i_fault_clr, FILL_TIMEOUT};
`endif

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    state_nxt = state;
    sel_nxt   = sel;
    duty_nxt  = duty;
    tick_nxt  = tick_cnt + 32'd1;
    dead_nxt  = 32'd0;

    case (state)
      IDLE: begin
        duty_nxt = 8'd0;
        tick_nxt = 32'd0;
        if (i_req_b) begin
          state_nxt = RAMP_UP;
          sel_nxt   = 1'b1;
        end else if (i_req_a) begin
          state_nxt = RAMP_UP;
          sel_nxt   = 1'b0;
        end
      end

      RAMP_UP: begin
        if (abort) begin
          // Ramp down from wherever the ramp-up had reached.
          state_nxt = RAMP_DOWN;
          tick_nxt  = 32'd0;
        end else if (duty == PWM_TARGET) begin
          state_nxt = RUN;
          tick_nxt  = 32'd0;
        end else if (tick_hit) begin
          duty_nxt = duty_up;
          tick_nxt = 32'd0;
          if (duty_up == PWM_TARGET) state_nxt = RUN;
        end
      end

      RUN: begin
        duty_nxt = PWM_TARGET;
        tick_nxt = 32'd0;
        if (abort) state_nxt = RAMP_DOWN;
      end

      RAMP_DOWN: begin
        // Requests are deliberately ignored here: a stop always completes.
        if (duty == 8'd0) begin
          state_nxt = DEAD;
          tick_nxt  = 32'd0;
        end else if (tick_hit) begin
          duty_nxt = duty_dn;
          tick_nxt = 32'd0;
          if (duty_dn == 8'd0) state_nxt = DEAD;
        end
      end

      DEAD: begin
        duty_nxt = 8'd0;
        tick_nxt = 32'd0;
        if (dead_cnt == DEAD_TIME - 32'd1) state_nxt = IDLE;
        else                                dead_nxt  = dead_cnt + 32'd1;
      end

`ifdef PUMP_SEQ_FILL_TIMEOUT_EN
      FAULT: begin
        duty_nxt = 8'd0;
        tick_nxt = 32'd0;
        if (i_fault_clr && !i_req_a && !i_req_b) state_nxt = IDLE;
      end
`endif

      default: begin
        state_nxt = IDLE;
        duty_nxt  = 8'd0;
        tick_nxt  = 32'd0;
      end
    endcase

`ifdef PUMP_SEQ_FILL_TIMEOUT_EN
    // The watchdog overrides every other transition; the pump stops at once.
    fill_nxt = 32'd0;
    if (fill_run) begin
      fill_nxt = fill_cnt + 32'd1;
      if (fill_cnt == FILL_TIMEOUT - 32'd1) begin
        state_nxt = FAULT;
        duty_nxt  = 8'd0;
        tick_nxt  = 32'd0;
        dead_nxt  = 32'd0;
        fill_nxt  = 32'd0;
      end
    end
`endif
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_fpga or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      sel      <= 1'b0;
      duty     <= 8'd0;
      tick_cnt <= 32'd0;
      dead_cnt <= 32'd0;
      o_duty_a <= 8'd0;
      o_duty_b <= 8'd0;
      o_busy   <= 1'b0;
    end else begin
      state    <= state_nxt;
      sel      <= sel_nxt;
      duty     <= duty_nxt;
      tick_cnt <= tick_nxt;
      dead_cnt <= dead_nxt;
      // Outputs are registered copies of the next state, so a single sel bit
      // steers the duty and both pumps can never be driven together.
      o_duty_a <= sel_nxt ? 8'd0 : duty_nxt;
      o_duty_b <= sel_nxt ? duty_nxt : 8'd0;
      o_busy   <= (state_nxt != IDLE);
    end
  end

`ifdef PUMP_SEQ_FILL_TIMEOUT_EN
  always_ff @(posedge clk_fpga or negedge reset) begin
    if (!reset) begin
      fill_cnt <= 32'd0;
      o_fault  <= 1'b0;
    end else begin
      fill_cnt <= fill_nxt;
      o_fault  <= (state_nxt == FAULT);
    end
  end
`else
  assign o_fault = 1'b0;
`endif

endmodule

// File: tb/tb_pump_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pump_sequencer
//   Scoreboard bench for pump_sequencer. Each stimulus step pushes the outputs
//   expected after the following clock edges. The outputs are sampled 1 time
//   unit after each rising edge, and every sample pops one entry from the
//   queue. Parameters: target 230, step 100, tick 4, dead time 3, timeout 20.
// -----------------------------------------------------------------------------
module tb_pump_sequencer;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       fault;
  } exp_t;

  logic       clk_fpga = 1'b0;
  logic       reset;
  logic       i_req_a;
  logic       i_req_b;
  logic       i_boia_cheia;
  logic       i_fault_clr;
  logic [7:0] o_duty_a;
  logic [7:0] o_duty_b;
  logic       o_busy;
  logic       o_fault;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  pump_sequencer #(
    .PWM_TARGET  (8'd230),
    .RAMP_STEP   (8'd100),
    .RAMP_TICK   (4),
    .DEAD_TIME   (3),
    .FILL_TIMEOUT(20)
  ) dut (
    .clk_fpga    (clk_fpga),
    .reset       (reset),
    .i_req_a     (i_req_a),
    .i_req_b     (i_req_b),
    .i_boia_cheia(i_boia_cheia),
    .i_fault_clr (i_fault_clr),
    .o_duty_a    (o_duty_a),
    .o_duty_b    (o_duty_b),
    .o_busy      (o_busy),
    .o_fault     (o_fault)
  );

  always #5 clk_fpga = ~clk_fpga;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic push(input logic [7:0] a, input logic [7:0] b,
                      input logic busy, input logic fault, input int n);
    exp_t e;
    e.a = a; e.b = b; e.busy = busy; e.fault = fault;
    repeat (n) exp_q.push_back(e);
  endtask

  // Expected ramp 0 -> 100 -> 200 -> 230 for the selected pump, four samples
  // per plateau, ending on the first sample at target.
  task automatic push_ramp_up(input logic pump_b);
    logic [7:0] lv [4];
    lv[0] = 8'd0; lv[1] = 8'd100; lv[2] = 8'd200; lv[3] = 8'd230;
    for (int i = 0; i < 4; i++)
      push(pump_b ? 8'd0 : lv[i], pump_b ? lv[i] : 8'd0, 1'b1, 1'b0, (i == 3) ? 1 : 4);
  endtask

  // Expected ramp 230 -> 130 -> 30 -> 0, three dead cycles, then one IDLE.
  task automatic push_ramp_down(input logic pump_b);
    logic [7:0] lv [3];
    lv[0] = 8'd230; lv[1] = 8'd130; lv[2] = 8'd30;
    for (int i = 0; i < 3; i++)
      push(pump_b ? 8'd0 : lv[i], pump_b ? lv[i] : 8'd0, 1'b1, 1'b0, 4);
    push(8'd0, 8'd0, 1'b1, 1'b0, 3);
    push(8'd0, 8'd0, 1'b0, 1'b0, 1);
  endtask

  task automatic step(input int n);
    exp_t e;
    repeat (n) begin
      @(posedge clk_fpga);
      #1;
      check("duties_exclusive", {31'd0, (o_duty_a != 8'd0) && (o_duty_b != 8'd0)}, 32'd0);
      if (exp_q.size() == 0) begin
        check("scoreboard_underflow", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("o_duty_a", {24'd0, o_duty_a}, {24'd0, e.a});
        check("o_duty_b", {24'd0, o_duty_b}, {24'd0, e.b});
        check("o_busy",   {31'd0, o_busy},   {31'd0, e.busy});
        check("o_fault",  {31'd0, o_fault},  {31'd0, e.fault});
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    reset        = 1'b0;
    i_req_a      = 1'b0;
    i_req_b      = 1'b0;
    i_boia_cheia = 1'b1;
    i_fault_clr  = 1'b0;

    // Reset state, before and during clocking.
    #1;
    check("rst_duty_a", {24'd0, o_duty_a}, 32'd0);
    check("rst_duty_b", {24'd0, o_duty_b}, 32'd0);
    check("rst_busy",   {31'd0, o_busy},   32'd0);
    check("rst_fault",  {31'd0, o_fault},  32'd0);
    push(8'd0, 8'd0, 1'b0, 1'b0, 2);
    step(2);
    reset = 1'b1;
    push(8'd0, 8'd0, 1'b0, 1'b0, 2);
    step(2);

    // Pump A: ramp up, hold, then stop; a request pulse and a stray fault
    // clear during the ramp-down must not disturb the sequence.
    i_req_a = 1'b1;
    push_ramp_up(1'b0);
    push(8'd230, 8'd0, 1'b1, 1'b0, 4);
    step(17);
    i_req_a = 1'b0;
    push_ramp_down(1'b0);
    push(8'd0, 8'd0, 1'b0, 1'b0, 2);
    step(6);
    i_req_a     = 1'b1;
    i_fault_clr = 1'b1;
    step(2);
    i_req_a     = 1'b0;
    i_fault_clr = 1'b0;
    step(10);

    // Both requests rise together: B is granted and A stays off.
    i_req_a = 1'b1;
    i_req_b = 1'b1;
    push_ramp_up(1'b1);
    push(8'd0, 8'd230, 1'b1, 1'b0, 2);
    step(1);
    i_req_a = 1'b0;
    step(14);

    // Hand-over B -> A: B ramps out, dead time, then A ramps in.
    i_req_a = 1'b1;
    push_ramp_down(1'b1);
    push(8'd0, 8'd0, 1'b1, 1'b0, 4);
    push(8'd100, 8'd0, 1'b1, 1'b0, 4);
    push(8'd200, 8'd0, 1'b1, 1'b0, 1);
    step(2);
    i_req_b = 1'b0;
    step(23);

    // Reset mid-ramp at duty 200: outputs clear without a clock edge.
    reset = 1'b0;
    #1;
    check("async_rst_duty_a", {24'd0, o_duty_a}, 32'd0);
    check("async_rst_busy",   {31'd0, o_busy},   32'd0);
    check("async_rst_duty_b", {24'd0, o_duty_b}, 32'd0);
    check("queue_drained_before_reset", exp_q.size(), 32'd0);
    push(8'd0, 8'd0, 1'b0, 1'b0, 2);
    step(2);

    // Request held through reset release: granted on the very first edge.
    reset = 1'b1;
    push(8'd0, 8'd0, 1'b1, 1'b0, 1);
    step(1);
    reset   = 1'b0;
    i_req_a = 1'b0;
    #1;
    check("second_rst_busy", {31'd0, o_busy}, 32'd0);
    reset = 1'b1;
    push(8'd0, 8'd0, 1'b0, 1'b0, 2);
    step(2);

`ifdef PUMP_SEQ_FILL_TIMEOUT_EN
    // Fill timeout: 20 cycles on pump A without the float trips FAULT.
    i_boia_cheia = 1'b0;
    i_req_a      = 1'b1;
    push_ramp_up(1'b0);
    push(8'd230, 8'd0, 1'b1, 1'b0, 7);
    push(8'd0, 8'd0, 1'b1, 1'b1, 2);
    step(22);
    i_fault_clr = 1'b1;              // ignored while a request is high
    push(8'd0, 8'd0, 1'b1, 1'b1, 1);
    step(1);
    i_req_a = 1'b0;                  // clear with requests low -> IDLE
    push(8'd0, 8'd0, 1'b0, 1'b0, 1);
    step(1);
    i_fault_clr  = 1'b0;
    i_boia_cheia = 1'b1;
    push(8'd0, 8'd0, 1'b0, 1'b0, 2);
    step(2);
`endif

    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
